// File: rtl/sseg_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sseg_pkg : shared types and constants for the seven-segment driver. Rev 1.0
// ---------------------------------------------------------------------------
package sseg_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD_HEX = 2'd1,
    SHIFT    = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam int                    NUM_DIGITS = 5;
  localparam logic [6:0]            BLANK_SEG  = 7'h7F;
  localparam logic [NUM_DIGITS-1:0] HEX_BLANK  = 5'b10000;

  // Active-low glyphs, bit 6 = CA ... bit 0 = CG.
  localparam logic [6:0] GLYPH_TABLE [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };

endpackage
`default_nettype wire

// File: rtl/sseg_driver_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sseg_driver_if : value/format in, display pins and busy out. Rev 1.0
// ---------------------------------------------------------------------------
interface sseg_driver_if;
  import sseg_pkg::*;

  logic [15:0]           value;
  logic                  dec;
  logic [6:0]            segments;
  logic [NUM_DIGITS-1:0] anodes;
  logic                  busy;

  modport master (output value, dec, input segments, anodes, busy);
  modport slave  (input value, dec, output segments, anodes, busy);

endinterface
`default_nettype wire

// File: rtl/sseg_driver_bin2bcd.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bin2bcd_seq : 16-bit to 5-digit BCD, one double-dabble step per cycle. Rev 1.0
// ---------------------------------------------------------------------------
module bin2bcd_seq
  import sseg_pkg::*;
(
  input  wire logic                    clk,
  input  wire logic                    rst_n,
  input  wire logic                    start,
  input  wire logic [15:0]             bin,
  output logic                         done,
  output logic [4*NUM_DIGITS-1:0]      bcd
);

  logic [15:0]               r_bin;
  logic [4*NUM_DIGITS-1:0]   r_bcd;
  logic [4*NUM_DIGITS-1:0]   w_adj;
  logic [4*NUM_DIGITS+15:0]  w_shift;
  logic [3:0]                r_step;
  logic                      r_active;

  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
    w_shift = {w_adj, r_bin} << 1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin    <= '0;
      r_bcd    <= '0;
      r_step   <= '0;
      r_active <= 1'b0;
    end else if (start) begin
      r_bin    <= bin;
      r_bcd    <= '0;
      r_step   <= '0;
      r_active <= 1'b1;
    end else if (r_active) begin
      {r_bcd, r_bin} <= w_shift;
      r_step         <= r_step + 4'd1;
      if (r_step == 4'd15) r_active <= 1'b0;
    end
  end

  // High during the cycle whose edge performs the sixteenth step.
  assign done = r_active && (r_step == 4'd15);
  assign bcd  = r_bcd;

endmodule
`default_nettype wire

// File: rtl/sseg_driver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sseg_driver : five-digit multiplexed seven-segment driver, hex or decimal.
// Define SSEG_DRIVER_LZ_BLANK_EN to blank decimal leading zeros. Rev 1.0
// ---------------------------------------------------------------------------
module sseg_driver
  import sseg_pkg::*;
#(
  parameter int C_REFRESH_DIV   = 1000,
  parameter bit C_SWAP_SEGMENTS = 1'b1
) (
  input  wire logic    clk,
  input  wire logic    rst_n,
  sseg_driver_if.slave bus
);

  localparam int               CNT_W    = (C_REFRESH_DIV > 1) ? $clog2(C_REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(C_REFRESH_DIV - 1);

  state_t                  r_state, w_next;
  logic [16:0]             r_capture;
  logic                    w_change, w_busy, w_start, w_cap_en, w_load_hex, w_load_dec;
  logic                    w_bcd_done;
  logic [4*NUM_DIGITS-1:0] w_bcd, r_shadow_dig;
  logic [NUM_DIGITS-1:0]   r_shadow_blank, w_dec_blank, r_anodes;
  logic [CNT_W-1:0]        r_cnt;
  logic [2:0]              r_idx;
  logic [3:0]              w_nib;
  logic [6:0]              w_glyph, w_seg, r_segments;

  assign w_change = ({bus.value, bus.dec} != r_capture);

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (w_start),
    .bin   (bus.value),
    .done  (w_bcd_done),
    .bcd   (w_bcd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (w_change) w_next = bus.dec ? SHIFT : LOAD_HEX;
      LOAD_HEX: w_next = IDLE;
      SHIFT:    if (w_bcd_done) w_next = DONE;
      DONE:     w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_comb begin
    w_busy     = 1'b0;
    w_cap_en   = 1'b0;
    w_start    = 1'b0;
    w_load_hex = 1'b0;
    w_load_dec = 1'b0;
    case (r_state)
      IDLE: begin
        w_cap_en = w_change;
        w_start  = w_change & bus.dec;
      end
      LOAD_HEX: w_load_hex = 1'b1;
      SHIFT:    w_busy     = 1'b1;
      DONE: begin
        w_busy     = 1'b1;
        w_load_dec = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.busy = w_busy;

`ifdef SSEG_DRIVER_LZ_BLANK_EN
  logic w_lead;
`endif

  always_comb begin
    w_dec_blank = '0;
`ifdef SSEG_DRIVER_LZ_BLANK_EN
    // A digit is blank only if it and every digit above it are zero.
    w_lead = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      w_lead         = w_lead & (w_bcd[4*i +: 4] == 4'd0);
      w_dec_blank[i] = w_lead;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_capture      <= '0;
      r_shadow_dig   <= '0;
      r_shadow_blank <= HEX_BLANK;
    end else begin
      if (w_cap_en) r_capture <= {bus.value, bus.dec};
      if (w_load_hex) begin
        r_shadow_dig   <= {4'h0, r_capture[16:1]};
        r_shadow_blank <= HEX_BLANK;
      end else if (w_load_dec) begin
        r_shadow_dig   <= w_bcd;
        r_shadow_blank <= w_dec_blank;
      end
    end
  end

  assign w_nib   = r_shadow_dig[{r_idx, 2'b00} +: 4];
  assign w_glyph = GLYPH_TABLE[w_nib];

  always_comb begin
    w_seg = w_glyph;
    if (C_SWAP_SEGMENTS) begin
      for (int b = 0; b < 7; b++) w_seg[b] = w_glyph[6-b];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_idx      <= '0;
      r_segments <= BLANK_SEG;
      r_anodes   <= '1;
    end else begin
      if (r_cnt == CNT_LAST) begin
        r_cnt <= '0;
        r_idx <= (r_idx == 3'(NUM_DIGITS - 1)) ? 3'd0 : r_idx + 3'd1;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (r_shadow_blank[r_idx]) begin
        r_segments <= BLANK_SEG;
        r_anodes   <= '1;
      end else begin
        r_segments <= w_seg;
        r_anodes   <= ~(NUM_DIGITS'(1) << r_idx);
      end
    end
  end

  assign bus.segments = r_segments;
  assign bus.anodes   = r_anodes;

endmodule
`default_nettype wire

// File: tb/tb_sseg_driver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sseg_driver : self-checking bench for sseg_driver (swap=1, short refresh). Rev 1.0
// ---------------------------------------------------------------------------
module tb_sseg_driver;

  localparam int DIV = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sseg_driver_if bus ();

  sseg_driver #(
    .C_REFRESH_DIV   (DIV),
    .C_SWAP_SEGMENTS (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [15:0] value;
    logic        dec;
    logic [19:0] dig;
    logic [4:0]  blank_lz;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [6:0]  exp_glyph [16];
  logic [19:0] disp_dig;
  logic [4:0]  disp_blank;
  vec_t        vecs [10];

  // Reference: digits from plain arithmetic on the number itself.
  function automatic logic [19:0] model_dig(input logic [15:0] v, input logic d);
    logic [19:0] r;
    int          x;
    r = '0;
    x = int'(v);
    for (int i = 0; i < 5; i++) begin
      if (d) begin
        r[4*i +: 4] = 4'(x % 10);
        x = x / 10;
      end else if (i < 4) begin
        r[4*i +: 4] = 4'((int'(v) >> (4*i)) & 15);
      end
    end
    return r;
  endfunction

  function automatic logic [4:0] model_blank(input logic [15:0] v, input logic d);
    logic [4:0] b;
    b = 5'b00000;
    if (!d) return 5'b10000;
`ifdef SSEG_DRIVER_LZ_BLANK_EN
    for (int i = 1; i < 5; i++) if (int'(v) < 10**i) b[i] = 1'b1;
`else
    if (v == 16'hFFFF) b = 5'b00000;
`endif
    return b;
  endfunction

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [15:0] v, input logic d);
    @(posedge clk);
    #1;
    bus.value = v;
    bus.dec   = d;
  endtask

  task automatic check_val(input string name, input logic [6:0] act, input logic [6:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Current pins must be either a fully blank slot or one lit, non-blank digit with its glyph.
  task automatic check_pins(input string name, input logic [19:0] dig, input logic [4:0] blank);
    int         k;
    bit         ok;
    logic [6:0] want;
    n_tests++;
    k  = -1;
    ok = 1'b1;
    want = 7'h7F;
    for (int i = 0; i < 5; i++) if (bus.anodes == ~(5'b00001 << i)) k = i;
    if (bus.anodes === 5'h1F) begin
      ok = (bus.segments === 7'h7F);
    end else if (k < 0) begin
      ok = 1'b0;
    end else begin
      want = exp_glyph[dig[4*k +: 4]];
      ok   = !blank[k] && (bus.segments === want);
    end
    if (!ok) begin
      n_fail++;
      $display("FAIL %s pins: anodes=%b segments=%h, required digit %0d glyph %h (digits %h blank %b)",
               name, bus.anodes, bus.segments, k, want, dig, blank);
    end
  endtask

  task automatic scan(input string name, input logic [19:0] dig, input logic [4:0] blank);
    int cnt [5];
    int nb;
    bit ok;
    cnt = '{default: 0};
    nb  = 0;
    for (int c = 0; c < 5*DIV; c++) begin
      cyc();
      check_pins(name, dig, blank);
      if (bus.anodes === 5'h1F) nb++;
      else for (int i = 0; i < 5; i++) if (bus.anodes == ~(5'b00001 << i)) cnt[i]++;
    end
    n_tests++;
    ok = (nb == DIV * $countones(blank));
    for (int i = 0; i < 5; i++) if (cnt[i] != (blank[i] ? 0 : DIV)) ok = 1'b0;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s slots: lit counts %0d %0d %0d %0d %0d blank %0d, required %0d per lit digit, blank mask %b",
               name, cnt[0], cnt[1], cnt[2], cnt[3], cnt[4], nb, DIV, blank);
    end
    disp_dig   = dig;
    disp_blank = blank;
  endtask

  task automatic check_busy(input string name, input logic req);
    n_tests++;
    if (bus.busy !== req) begin
      n_fail++;
      $display("FAIL %s busy: got %b, required %b", name, bus.busy, req);
    end
  endtask

  // Called right after an input change (or reset release) at edge N.
  task automatic dec_window(input string name, input logic [19:0] new_dig, input logic [4:0] new_blank);
    for (int j = 1; j <= 20; j++) begin
      cyc();
      check_busy(name, j <= 17);
      if (j <= 18) check_pins({name, "_old"}, disp_dig, disp_blank);
      else         check_pins({name, "_new"}, new_dig, new_blank);
    end
    scan(name, new_dig, new_blank);
  endtask

  task automatic settle_scan(input string name, input logic [15:0] v, input logic d,
                             input logic [19:0] dig, input logic [4:0] blank);
    drive(v, d);
    repeat (20) cyc();
    check_busy(name, 1'b0);
    scan(name, dig, blank);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0]  b;
    logic [15:0] rv;
    logic        rd;

    exp_glyph = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    vecs[0] = '{16'h1234, 1'b0, 20'h01234, 5'b10000};
    vecs[1] = '{16'hABCD, 1'b0, 20'h0ABCD, 5'b10000};
    vecs[2] = '{16'hFFFF, 1'b0, 20'h0FFFF, 5'b10000};
    vecs[3] = '{16'd65535, 1'b1, 20'h65535, 5'b00000};
    vecs[4] = '{16'd0,     1'b1, 20'h00000, 5'b11110};
    vecs[5] = '{16'd10000, 1'b1, 20'h10000, 5'b00000};
    vecs[6] = '{16'd12345, 1'b1, 20'h12345, 5'b00000};
    vecs[7] = '{16'h0007,  1'b0, 20'h00007, 5'b10000};
    vecs[8] = '{16'd90,    1'b1, 20'h00090, 5'b11100};
    vecs[9] = '{16'h0000,  1'b0, 20'h00000, 5'b10000};

    // Reset state and first edge after release
    bus.value = 16'h0;
    bus.dec   = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_segments", bus.segments, 7'h7F);
    check_val("rst_anodes", {2'b00, bus.anodes}, 7'h1F);
    check_busy("rst", 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc();
    check_val("first_anodes", {2'b00, bus.anodes}, 7'h1E);
    check_val("first_segments", bus.segments, 7'h40);
    check_busy("first", 1'b0);
    disp_dig   = 20'h0;
    disp_blank = 5'b10000;
    scan("reset_zero", 20'h00000, 5'b10000);

    // Hex latency: old glyphs two edges after the change, new on the third
    drive(16'h1234, 1'b0);
    cyc();
    check_busy("hex_lat1", 1'b0);
    cyc();
    check_pins("hex_lat_old", disp_dig, disp_blank);
    cyc();
    check_pins("hex_lat_new", 20'h01234, 5'b10000);
    scan("hex_1234", 20'h01234, 5'b10000);

    // Decimal conversion of full scale
    drive(16'd65535, 1'b1);
    dec_window("dec_65535", 20'h65535, 5'b00000);

    // Format toggle with unchanged value
    settle_scan("hex_7", 16'd7, 1'b0, 20'h00007, 5'b10000);
    drive(16'd7, 1'b1);
`ifdef SSEG_DRIVER_LZ_BLANK_EN
    dec_window("toggle_7", 20'h00007, 5'b11110);
`else
    dec_window("toggle_7", 20'h00007, 5'b00000);
`endif

    // Value changed during SHIFT: first result lands, second conversion follows
    drive(16'd12345, 1'b1);
    for (int j = 1; j <= 40; j++) begin
      cyc();
      if (j == 6) bus.value = 16'd54321;
      check_busy("midchg", (j <= 17) || (j >= 19 && j <= 35));
      if (j <= 18)      check_pins("midchg_old", disp_dig, disp_blank);
      else if (j <= 36) check_pins("midchg_first", 20'h12345, 5'b00000);
      else              check_pins("midchg_second", 20'h54321, 5'b00000);
    end
    scan("midchg_54321", 20'h54321, 5'b00000);

    // Reset pulse during SHIFT, then a fresh conversion of the live value
    drive(16'd999, 1'b1);
    repeat (3) cyc();
    #1 rst_n = 1'b0;
    #1;
    check_val("midrst_segments", bus.segments, 7'h7F);
    check_val("midrst_anodes", {2'b00, bus.anodes}, 7'h1F);
    check_busy("midrst", 1'b0);
    repeat (2) @(negedge clk);
    check_busy("midrst_hold", 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    disp_dig   = 20'h0;
    disp_blank = 5'b10000;
    dec_window("postrst_999", 20'h00999, model_blank(16'd999, 1'b1));

    // Table vectors
    for (int i = 0; i < 10; i++) begin
`ifdef SSEG_DRIVER_LZ_BLANK_EN
      b = vecs[i].blank_lz;
`else
      b = vecs[i].dec ? 5'b00000 : vecs[i].blank_lz;
`endif
      settle_scan($sformatf("vec%0d", i), vecs[i].value, vecs[i].dec, vecs[i].dig, b);
    end

    // Randomized values and formats against the arithmetic model
    for (int i = 0; i < 12; i++) begin
      rv = 16'($urandom_range(0, 65535));
      rd = 1'($urandom_range(0, 1));
      settle_scan($sformatf("rand%0d_%0d_%0d", i, rv, rd), rv, rd, model_dig(rv, rd), model_blank(rv, rd));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
